// File: rtl/sweep_ctrl_if.sv
// Bus between the sweep controller and its environment: sweep commands in,
// counter readback in, counter control and status out.
interface sweep_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 8
);
  logic              i_start;
  logic              i_stop;
  logic [WIDTH-1:0]  i_limit;
  logic [PWIDTH-1:0] i_passes;
  logic [WIDTH-1:0]  i_q;
  logic              o_cnt_en;
  logic              o_up_down;
  logic              o_ctr_clr;
  logic              o_busy;
  logic              o_done;
  logic [PWIDTH-1:0] o_pass_cnt;
  logic              o_err;

  // Environment side: issues commands and returns the counter value
  modport master (
    output i_start, i_stop, i_limit, i_passes, i_q,
    input  o_cnt_en, o_up_down, o_ctr_clr, o_busy, o_done, o_pass_cnt, o_err
  );

  // Controller side
  modport slave (
    input  i_start, i_stop, i_limit, i_passes, i_q,
    output o_cnt_en, o_up_down, o_ctr_clr, o_busy, o_done, o_pass_cnt, o_err
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Up/down sweep controller driving an external counter between 0 and a
// latched limit for a requested number of half-sweeps (0 = forever).
module sweep_ctrl #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_sclr,
  sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_UP     = 3'd2,
    S_DOWN   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_lim;
  logic [PWIDTH-1:0] r_pas;
  logic [PWIDTH-1:0] r_pc;
  logic              r_err;

  logic              w_run;
  logic              w_over;
  logic              w_up_turn;
  logic              w_dn_turn;
  logic [PWIDTH-1:0] w_pc_inc;
  logic              w_last;

  assign w_run     = (r_state == S_UP) || (r_state == S_DOWN);
  // Counter escaped the window (e.g. external disturbance); checked in both directions
  assign w_over    = w_run && (bus.i_q > r_lim);
  assign w_up_turn = (r_state == S_UP)   && (bus.i_q == r_lim);
  assign w_dn_turn = (r_state == S_DOWN) && (bus.i_q == '0);
  assign w_pc_inc  = r_pc + 1'b1;
  // Pass count reached the target; never true in continuous mode
  assign w_last    = (r_pas != '0) && (w_pc_inc == r_pas);

  // Counter control decoded from state and Q; Sclr also clears the counter
  always_comb begin
    bus.o_cnt_en  = 1'b0;
    bus.o_up_down = 1'b0;
    bus.o_ctr_clr = i_sclr || (r_state == S_CLEAR);
    bus.o_busy    = 1'b0;
    bus.o_done    = 1'b0;
    if (!i_sclr) begin
      bus.o_up_down = (r_state == S_CLEAR) || (r_state == S_UP);
      bus.o_busy    = (r_state == S_CLEAR) || w_run;
      bus.o_done    = (r_state == S_FINISH);
      if (!bus.i_stop && !w_over)
        bus.o_cnt_en = ((r_state == S_UP)   && (bus.i_q != r_lim)) ||
                       ((r_state == S_DOWN) && (bus.i_q != '0));
    end
  end

  assign bus.o_pass_cnt = r_pc;
  assign bus.o_err      = r_err;

  // Sweep FSM; overrun beats Stop, Stop beats turnaround
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_state <= S_IDLE;
      r_lim   <= '0;
      r_pas   <= '0;
      r_pc    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            if (bus.i_limit != '0) begin
              r_lim   <= bus.i_limit;
              r_pas   <= bus.i_passes;
              r_pc    <= '0;
              r_err   <= 1'b0;
              r_state <= S_CLEAR;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        S_CLEAR: r_state <= bus.i_stop ? S_FINISH : S_UP;
        S_UP, S_DOWN: begin
          if (w_over) begin
            r_err   <= 1'b1;
            r_state <= S_FINISH;
          end else if (bus.i_stop) begin
            r_state <= S_FINISH;
          end else if (w_up_turn || w_dn_turn) begin
            r_pc    <= w_pc_inc;
            r_state <= w_last ? S_FINISH : (w_up_turn ? S_DOWN : S_UP);
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with a behavioural up/down counter closing the Q loop.
module tb_sweep_ctrl;

  logic clk  = 1'b0;
  logic sclr = 1'b1;
  always #5 clk = ~clk;

  sweep_ctrl_if #(.WIDTH(16), .PWIDTH(8)) bus ();

  sweep_ctrl #(.WIDTH(16), .PWIDTH(8)) dut (
    .i_clk  (clk),
    .i_sclr (sclr),
    .bus    (bus)
  );

  // External counter: sync clear, enable, direction, plus a bench override for overrun tests
  logic        force_en  = 1'b0;
  logic [15:0] force_val = '0;
  initial bus.i_q = '0;
  always @(posedge clk) begin
    if (bus.o_ctr_clr)     bus.i_q <= '0;
    else if (force_en)     bus.i_q <= force_val;
    else if (bus.o_cnt_en) bus.i_q <= bus.o_up_down ? bus.i_q + 16'd1 : bus.i_q - 16'd1;
  end

  typedef struct {
    logic        sclr, start, stop;
    logic [15:0] lim;
    logic [7:0]  pas;
    logic [29:0] exp;   // {q, cnt_en, up_down, ctr_clr, busy, done, pass_cnt, err}
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic s, st, sp, input logic [15:0] l, input logic [7:0] p,
                              input logic [15:0] q, input logic en, ud, clr, bsy, dn,
                              input logic [7:0] pc, input logic er);
    vec_t v;
    v.sclr = s; v.start = st; v.stop = sp; v.lim = l; v.pas = p;
    v.exp = {q, en, ud, clr, bsy, dn, pc, er};
    vq.push_back(v);
  endfunction

  function automatic logic [29:0] outs();
    return {bus.i_q, bus.o_cnt_en, bus.o_up_down, bus.o_ctr_clr, bus.o_busy,
            bus.o_done, bus.o_pass_cnt, bus.o_err};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic st, sp, input logic [15:0] l, input logic [7:0] p);
    bus.i_start = st; bus.i_stop = sp; bus.i_limit = l; bus.i_passes = p;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  int   ud_bad, pc_bad, dn_cnt, wrap_seen;
  int   prev_pc;
  logic got40;

  initial begin
    drive(0, 0, 0, 0);
    // reset, idle
    add(1,0,0,0,0, 0,0,0,1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // basic run: Limit=3, Passes=2; stray Starts while busy and in FINISH
    add(0,1,0,3,2, 0,0,0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,1,1,1,0,0,0);
    add(0,0,0,0,0, 0,1,1,0,1,0,0,0);
    add(0,1,0,0,0, 1,1,1,0,1,0,0,0);
    add(0,0,0,0,0, 2,1,1,0,1,0,0,0);
    add(0,0,0,0,0, 3,0,1,0,1,0,0,0);
    add(0,0,0,0,0, 3,1,0,0,1,0,1,0);
    add(0,0,0,0,0, 2,1,0,0,1,0,1,0);
    add(0,0,0,0,0, 1,1,0,0,1,0,1,0);
    add(0,0,0,0,0, 0,0,0,0,1,0,1,0);
    add(0,1,0,3,0, 0,0,0,0,0,1,2,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,2,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,2,0);
    // zero limit: Err, stays idle, Pass_Cnt holds
    add(0,1,0,0,5, 0,0,0,0,0,0,2,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,2,1);
    add(0,0,0,0,0, 0,0,0,0,0,0,2,1);
    // accepted Start clears Err; Limit=2 Passes=1 ends at the top
    add(0,1,0,2,1, 0,0,0,0,0,0,2,1);
    add(0,0,0,0,0, 0,0,1,1,1,0,0,0);
    add(0,0,0,0,0, 0,1,1,0,1,0,0,0);
    add(0,0,0,0,0, 1,1,1,0,1,0,0,0);
    add(0,0,0,0,0, 2,0,1,0,1,0,0,0);
    add(0,0,0,0,0, 2,0,0,0,0,1,1,0);
    add(0,0,0,0,0, 2,0,0,0,0,0,1,0);
    // Stop on a turnaround cycle: no increment
    add(0,1,0,1,0, 2,0,0,0,0,0,1,0);
    add(0,0,0,0,0, 2,0,1,1,1,0,0,0);
    add(0,0,0,0,0, 0,1,1,0,1,0,0,0);
    add(0,0,1,0,0, 1,0,1,0,1,0,0,0);
    add(0,0,0,0,0, 1,0,0,0,0,1,0,0);
    add(0,0,0,0,0, 1,0,0,0,0,0,0,0);
    // Sclr in DOWN at Q=5 with Start held: counter cleared, no Done, Start ignored
    add(0,1,0,7,0, 1,0,0,0,0,0,0,0);
    add(0,0,0,0,0, 1,0,1,1,1,0,0,0);
    for (int i = 0; i < 7; i++) add(0,0,0,0,0, 16'(i),1,1,0,1,0,0,0);
    add(0,0,0,0,0, 7,0,1,0,1,0,0,0);
    add(0,0,0,0,0, 7,1,0,0,1,0,1,0);
    add(0,0,0,0,0, 6,1,0,0,1,0,1,0);
    add(1,1,0,7,0, 5,0,0,1,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0);

    sclr = 1'b1;
    repeat (2) @(negedge clk);
    foreach (vq[i]) begin
      sclr = vq[i].sclr;
      drive(vq[i].start, vq[i].stop, vq[i].lim, vq[i].pas);
      #1;
      n_vec++;
      if (outs() !== vq[i].exp) begin
        n_err++;
        $display("FAIL vec%0d: got %h expected %h", i, outs(), vq[i].exp);
      end
      @(negedge clk);
    end
    #1;

    // Stop mid-sweep at Q=40, Limit=100, continuous
    drive(1, 0, 100, 0); step();
    drive(0, 0, 0, 0);
    got40 = 1'b0;
    for (int k = 0; k < 200 && !got40; k++) begin
      step();
      if (bus.i_q == 16'd40) got40 = 1'b1;
    end
    chk("stop_reach40", int'(got40), 1);
    bus.i_stop = 1'b1; #1;
    chk("stop_en", int'(bus.o_cnt_en), 0);
    chk("stop_busy", int'(bus.o_busy), 1);
    step(); bus.i_stop = 1'b0;
    chk("stop_done", int'(bus.o_done), 1);
    chk("stop_q", int'(bus.i_q), 40);
    chk("stop_pc", int'(bus.o_pass_cnt), 0);
    step();
    chk("stop_q_hold", int'(bus.i_q), 40);
    chk("stop_idle", int'(bus.o_busy), 0);

    // Continuous mode, Limit=1: 600 half-sweeps, two cycles each
    drive(1, 0, 1, 0); step();
    drive(0, 0, 0, 0); step();
    ud_bad = 0; pc_bad = 0; dn_cnt = 0; wrap_seen = 0; prev_pc = 0;
    for (int k = 0; k < 1200; k++) begin
      if (bus.o_up_down !== (((k / 2) % 2) == 0)) ud_bad++;
      if (int'(bus.o_pass_cnt) != (k / 2) % 256) pc_bad++;
      if (bus.o_done) dn_cnt++;
      if (prev_pc == 255 && bus.o_pass_cnt == 8'd0) wrap_seen = 1;
      prev_pc = int'(bus.o_pass_cnt);
      step();
    end
    chk("cont_updown", ud_bad, 0);
    chk("cont_pc_track", pc_bad, 0);
    chk("cont_no_done", dn_cnt, 0);
    chk("cont_wrap", wrap_seen, 1);
    chk("cont_final_pc", int'(bus.o_pass_cnt), 88);
    chk("cont_busy", int'(bus.o_busy), 1);
    bus.i_stop = 1'b1; step(); bus.i_stop = 1'b0;
    chk("cont_stop_done", int'(bus.o_done), 1);
    step();

    // Overrun: Q forced to 9 with Lim_r=7 while in UP
    drive(1, 0, 7, 0); step();
    drive(0, 0, 0, 0);
    repeat (3) step();
    chk("ovr_pre_q", int'(bus.i_q), 2);
    force_en = 1'b1; force_val = 16'd9;
    step();
    force_en = 1'b0;
    chk("ovr_q", int'(bus.i_q), 9);
    chk("ovr_en", int'(bus.o_cnt_en), 0);
    chk("ovr_busy", int'(bus.o_busy), 1);
    bus.i_stop = 1'b1; #1;
    chk("ovr_en_stop", int'(bus.o_cnt_en), 0);
    step(); bus.i_stop = 1'b0;
    chk("ovr_done", int'(bus.o_done), 1);
    chk("ovr_err", int'(bus.o_err), 1);
    step();
    chk("ovr_err_hold", int'(bus.o_err), 1);
    drive(1, 0, 2, 1); step();
    drive(0, 0, 0, 0);
    chk("ovr_err_clr", int'(bus.o_err), 0);
    chk("ovr_restart_clr", int'(bus.o_ctr_clr), 1);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, width of the counter value and limit.
REQ-002 Parameter: PWIDTH, 8, width of the pass request and pass counter.
REQ-003 Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Sclr  in  1  reset: synchronous, active-high.
REQ-005 Start  in  1  request to begin a sweep; sampled only in IDLE.
REQ-006 Stop  in  1  abort the running sweep.
REQ-007 Limit  in  WIDTH  sweep upper bound; latched into Lim_r on accepted Start.
REQ-008 Passes  in  PWIDTH  number of half-sweeps to run; 0 = continuous; latched into Pas_r on accepted Start.
REQ-009 Q  in  WIDTH  registered value from the 16-bit up/down counter; changes one cycle after Cnt_En.
REQ-010 Cnt_En  out  1  counter enable.
REQ-011 UpDown  out  1  counter direction; 1 = up, 0 = down.
REQ-012 Ctr_Clr  out  1  drives the counter's synchronous clear.
REQ-013 Busy  out  1  high in CLEAR, UP and DOWN.
REQ-014 Done  out  1  one-cycle pulse in FINISH.
REQ-015 Pass_Cnt  out  PWIDTH  number of half-sweeps completed in the current or last run.
REQ-016 Err  out  1  sticky error flag.

Function
REQ-017 The FSM SHALL have five states: IDLE, CLEAR, UP, DOWN, FINISH.
REQ-018 In IDLE:
- Start=1 with Limit!=0: latch Lim_r and Pas_r, clear Pass_Cnt and Err, go to CLEAR.
- Start=1 with Limit==0: set Err, stay in IDLE.
REQ-019 CLEAR SHALL last exactly one cycle with Ctr_Clr=1, Cnt_En=0, UpDown=1; the next state is UP.
REQ-020 In UP, UpDown=1 and Cnt_En=(Q!=Lim_r), decoded combinationally from state and Q.
REQ-021 Up turnaround: in UP with Q==Lim_r (Cnt_En=0 that cycle), Pass_Cnt increments.
- If Pas_r!=0 and the incremented Pass_Cnt equals Pas_r, go to FINISH.
- Otherwise go to DOWN.
REQ-022 In DOWN, UpDown=0 and Cnt_En=(Q!=0).
REQ-023 Down turnaround: in DOWN with Q==0, Pass_Cnt increments.
- If Pas_r!=0 and the incremented Pass_Cnt equals Pas_r, go to FINISH.
- Otherwise go to UP.
REQ-024 Pass_Cnt SHALL wrap from 2^PWIDTH-1 to 0; in continuous mode (Pas_r==0) the run never terminates on pass count.
REQ-025 Stop=1 in CLEAR, UP or DOWN:
- Force Cnt_En=0 that same cycle and go to FINISH.
- Pass_Cnt is not incremented, even on a turnaround cycle.
REQ-026 Overrun: in UP with Q>Lim_r, or in DOWN with Q>Lim_r:
- Set Err, force Cnt_En=0, go to FINISH.
- Overrun has priority over Stop and over a turnaround.
REQ-027 FINISH SHALL last one cycle with Done=1, Busy=0, Cnt_En=0; the next state is IDLE.
REQ-028 Start while not in IDLE SHALL be ignored, and Start in the FINISH cycle SHALL be ignored.
REQ-029 In IDLE and FINISH, UpDown SHALL be 0 and Ctr_Clr SHALL be 0.
REQ-030 Pass_Cnt and Err SHALL hold their values in IDLE until the next accepted Start or Sclr.
REQ-031 Busy and Done SHALL be decoded from state only, with no dependence on Q.

Reset
REQ-032 Sclr=1 SHALL, on the next edge, force state IDLE, Lim_r=0, Pas_r=0, Pass_Cnt=0 and Err=0, regardless of current state.
REQ-033 While Sclr=1: Ctr_Clr=1, Cnt_En=0, UpDown=0, Busy=0, Done=0, so the counter is cleared together with the controller.
REQ-034 Sclr SHALL have priority over Start, Stop and every FSM transition.
REQ-035 Sclr asserted mid-sweep SHALL produce no Done pulse.

Verification
REQ-036 Basic run: Start at cycle 0, Limit=3, Passes=2 ->
- cycle 1: CLEAR.
- cycles 2-5: UP, Q=0,1,2,3, Cnt_En=1,1,1,0.
- cycles 6-9: DOWN, Q=3,2,1,0, Cnt_En=1,1,1,0.
- cycle 10: Done=1, Pass_Cnt=2.
- cycle 11: IDLE, Busy=0.
REQ-037 Zero limit: Start with Limit=0 -> Err=1 next cycle, Busy stays 0, Cnt_En never asserted, no Done.
REQ-038 Stop: Limit=100, Passes=0, Stop when Q=40 in UP -> Cnt_En=0 that cycle, Done next cycle, Pass_Cnt=0, Q holds 40.
REQ-039 Continuous mode: Limit=1, Passes=0, run 600 half-sweeps ->
- Pass_Cnt wraps 255->0.
- UpDown alternates every 2 cycles.
- Done is never asserted.
REQ-040 Reset mid-run: Sclr in DOWN at Q=5 ->
- Ctr_Clr=1 during the Sclr cycle, then Q=0.
- All outputs 0, no Done.
- Start ignored while Sclr=1.
REQ-041 Overrun: force Q=9 with Lim_r=7 in UP -> Err=1, Cnt_En=0 that cycle, Done next cycle; the next accepted Start clears Err.
